dmi_responder: RTL and testbench
================================

# dmi_responder

Debug Module side of the DMI link: accepts one DMI request at a time from the JTAG DTM (valid/ready), performs the read or write on the Debug Module register bus, and returns a status-coded response (valid/ready). It sits between the DTM's DMI request/response channels and the DM register block, and bounds every register access with a timeout.

## Interface
Parameters:
- `ABITS`, 7: DMI address width.
- `TIMEOUT`, 16: maximum cycles to wait for `reg_ack` (≥2).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `dmi_req_valid`  in  1  request present.
- `dmi_req_ready`  out  1  responder can accept a request.
- `dmi_req_addr`  in  ABITS  DM register address.
- `dmi_req_data`  in  32  write data.
- `dmi_req_op`  in  2  0 NOP, 1 READ, 2 WRITE, 3 reserved.
- `dmi_resp_valid`  out  1  response present.
- `dmi_resp_ready`  in  1  DTM takes the response.
- `dmi_resp_data`  out  32  read data (0 for non-reads and failures).
- `dmi_resp_op`  out  2  0 success, 2 op failed, 3 busy.
- `reg_rd_en`, `reg_wr_en`  out  1  register bus strobes, held until ack or timeout.
- `reg_addr`  out  ABITS  captured address.
- `reg_wdata`  out  32  captured write data.
- `reg_rdata`  in  32  read data, valid with `reg_ack`.
- `reg_ack`  in  1  access complete.
- `reg_err`  in  1  access error, sampled with `reg_ack`.

## Operation
- States: Idle, Access, Respond.
- Idle: `dmi_req_ready`=1. On `dmi_req_valid & dmi_req_ready`, capture addr, data and op.
  - NOP: go to Respond with op 0, data 0.
  - READ or WRITE: go to Access and clear the wait counter.
  - Reserved op 3: go to Respond with op 2, data 0. No bus access.
- Access: `reg_rd_en` (READ) or `reg_wr_en` (WRITE) high. `reg_addr`/`reg_wdata` hold the captured values. Counter increments each cycle.
  - `reg_ack`: go to Respond. Op is 2 if `reg_err`, else 0. Data is `reg_rdata` only for a successful READ, else 0.
  - No ack and counter == TIMEOUT-1: go to Respond with op 2, data 0.
  - Ack in the same cycle as the timeout: the ack wins.
- Respond: `dmi_resp_valid`=1. `dmi_resp_data`/`dmi_resp_op` stay stable until `dmi_resp_ready`, then go to Idle.
- `dmi_req_ready`=0 outside Idle. A request is never accepted in the same cycle as a response handshake.
- Busy code 3 is never produced: requests stall via ready instead.
- Reset (any state, including mid-access or mid-response): state returns to Idle and the pending request is discarded with no response.
  - Reset values: `dmi_req_ready`=0 while reset is high, 1 the cycle after.
  - All other outputs 0: `dmi_resp_valid`, `dmi_resp_data`, `dmi_resp_op`, `reg_rd_en`, `reg_wr_en`, `reg_addr`, `reg_wdata`.

## Timing
- Request handshake at edge N.
  - NOP or reserved op: `dmi_resp_valid` is high from N+1.
  - READ/WRITE: strobe is high from N+1. If `reg_ack` is present in cycle N+1, `dmi_resp_valid` rises at N+2 (minimum access latency 2).
- Timeout: strobe is high for exactly TIMEOUT cycles, then `dmi_resp_valid` rises on the next edge.
- Response handshake at edge M: Idle with `dmi_req_ready`=1 from M+1. Minimum request spacing is 3 cycles for READ/WRITE, 2 for NOP.
- Strobes and the captured fields are registered and glitch-free. `dmi_req_ready` and `dmi_resp_valid` decode directly from the state.

## Structure
- Shared package `dm_pkg` holds:
  - DMI op encodings (NOP/READ/WRITE).
  - Response codes (SUCCESS=0, FAILED=2, BUSY=3).
  - The responder state enum.
- The DTM-side FSM imports the same package.
- One sub-module: `dmi_timeout_ctr`, a parameterised saturating counter with `clear`, `inc` and `expired` (count == TIMEOUT-1).
- Everything else stays in `dmi_responder`.

## Test plan
- Reset, then WRITE addr 0x10 data 0xDEADBEEF, ack on the first Access cycle:
  - `reg_wr_en` is high exactly 1 cycle with addr 0x10 and wdata 0xDEADBEEF.
  - Response op 0, data 0 at N+2.
- READ addr 0x04, ack after 3 cycles with rdata 0x12345678, `dmi_resp_ready` held low 5 cycles:
  - Response op 0, data 0x12345678, stable until the ready handshake.
  - `dmi_req_ready` stays low throughout.
- READ with no ack, TIMEOUT=16:
  - `reg_rd_en` high for 16 cycles, then response op 2, data 0.
  - Repeat with ack arriving on cycle 16: response op 0.
- NOP, reserved op 3, and a WRITE acked with `reg_err`=1:
  - NOP responds op 0 at N+1.
  - Reserved op responds op 2 at N+1, with no strobe.
  - Errored WRITE responds op 2.
- Reset mid-Access and mid-Respond:
  - Strobe and `dmi_resp_valid` drop after the reset edge, and no stale response appears.
  - The next READ completes normally.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: encodings shared by the DMI responder (DM side) and the DTM FSM.
//   - DMI request op encodings (NOP/READ/WRITE; 3 is reserved)
//   - DMI response codes (SUCCESS/FAILED/BUSY)
//   - responder state enum
package dm_pkg;

  typedef logic [1:0] dmi_op_t;

  localparam dmi_op_t DMI_OP_NOP   = 2'd0;
  localparam dmi_op_t DMI_OP_READ  = 2'd1;
  localparam dmi_op_t DMI_OP_WRITE = 2'd2;

  localparam dmi_op_t DMI_RESP_SUCCESS = 2'd0;
  localparam dmi_op_t DMI_RESP_FAILED  = 2'd2;
  localparam dmi_op_t DMI_RESP_BUSY    = 2'd3;

  typedef enum logic [1:0] {
    RSP_IDLE    = 2'd0,
    RSP_ACCESS  = 2'd1,
    RSP_RESPOND = 2'd2
  } rsp_state_e;

  // READ and WRITE are the only ops that touch the register bus.
  function automatic logic is_bus_op(input dmi_op_t op);
    return (op == DMI_OP_READ) || (op == DMI_OP_WRITE);
  endfunction

endpackage

// File: rtl/dmi_responder_if.sv
// dmi_responder_if: DMI request/response channels plus the DM register bus.
//   slave  : the responder (accepts DMI requests, drives the register bus)
//   master : the environment (DTM side + register block)
//   DMI req : dmi_req_valid/ready, dmi_req_addr[ABITS], dmi_req_data[32], dmi_req_op[2]
//   DMI resp: dmi_resp_valid/ready, dmi_resp_data[32], dmi_resp_op[2]
//   Reg bus : reg_rd_en, reg_wr_en, reg_addr[ABITS], reg_wdata[32],
//             reg_rdata[32], reg_ack, reg_err
interface dmi_responder_if #(
  parameter int ABITS = 7
);
  logic             dmi_req_valid;
  logic             dmi_req_ready;
  logic [ABITS-1:0] dmi_req_addr;
  logic [31:0]      dmi_req_data;
  logic [1:0]       dmi_req_op;

  logic             dmi_resp_valid;
  logic             dmi_resp_ready;
  logic [31:0]      dmi_resp_data;
  logic [1:0]       dmi_resp_op;

  logic             reg_rd_en;
  logic             reg_wr_en;
  logic [ABITS-1:0] reg_addr;
  logic [31:0]      reg_wdata;
  logic [31:0]      reg_rdata;
  logic             reg_ack;
  logic             reg_err;

  modport slave (
    input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op,
    output dmi_req_ready,
    output dmi_resp_valid, dmi_resp_data, dmi_resp_op,
    input  dmi_resp_ready,
    output reg_rd_en, reg_wr_en, reg_addr, reg_wdata,
    input  reg_rdata, reg_ack, reg_err
  );

  modport master (
    output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op,
    input  dmi_req_ready,
    input  dmi_resp_valid, dmi_resp_data, dmi_resp_op,
    output dmi_resp_ready,
    input  reg_rd_en, reg_wr_en, reg_addr, reg_wdata,
    output reg_rdata, reg_ack, reg_err
  );
endinterface

// File: rtl/dmi_timeout_ctr.sv
// dmi_timeout_ctr: saturating wait counter for register accesses.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart from 0 (wins over inc)
//   inc        : count up by one, saturating at TIMEOUT-1
//   expired    : count == TIMEOUT-1
module dmi_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int            CW    = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CMAX  = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)                      r_cnt <= '0;
    else if (clear)                 r_cnt <= '0;
    else if (inc && (r_cnt != CMAX)) r_cnt <= r_cnt + 1'b1;
  end

  assign expired = (r_cnt == CMAX);
endmodule

// File: rtl/dmi_responder.sv
// dmi_responder: DM side of the DMI link. Takes one request at a time,
// performs it on the DM register bus with a bounded wait, and returns a
// status-coded response.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : dmi_responder_if.slave (DMI req/resp channels + reg bus)
// Parameters: ABITS (DMI address width), TIMEOUT (max ack wait, >= 2).
module dmi_responder
  import dm_pkg::*;
#(
  parameter int ABITS   = 7,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  dmi_responder_if.slave   bus
);

  rsp_state_e       r_state;
  rsp_state_e       w_next;

  logic             w_req_ready;
  logic             w_resp_valid;
  logic             w_accept;
  logic             w_resp_hs;
  logic             w_expired;
  logic             w_done;

  dmi_op_t          r_op;
  logic [ABITS-1:0] r_addr;
  logic [31:0]      r_wdata;
  logic             r_rd_en;
  logic             r_wr_en;
  logic [31:0]      r_resp_data;
  dmi_op_t          r_resp_op;

  assign w_accept  = bus.dmi_req_valid && w_req_ready;
  assign w_resp_hs = w_resp_valid && bus.dmi_resp_ready;
  // Ack and timeout in the same cycle both end the access; the datapath
  // below gives the ack priority when forming the response.
  assign w_done    = (r_state == RSP_ACCESS) && (bus.reg_ack || w_expired);

  dmi_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_accept),
    .inc     (r_state == RSP_ACCESS),
    .expired (w_expired)
  );

  // --- FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= RSP_IDLE;
    else       r_state <= w_next;
  end

  // --- FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      RSP_IDLE:    if (w_accept) w_next = is_bus_op(bus.dmi_req_op) ? RSP_ACCESS : RSP_RESPOND;
      RSP_ACCESS:  if (w_done)   w_next = RSP_RESPOND;
      RSP_RESPOND: if (w_resp_hs) w_next = RSP_IDLE;
      default:     w_next = RSP_IDLE;
    endcase
  end

  // --- FSM: outputs. Ready is masked by reset so nothing is offered or
  // accepted while reset is asserted.
  always_comb begin
    w_req_ready  = (r_state == RSP_IDLE) && !reset;
    w_resp_valid = (r_state == RSP_RESPOND);
  end

  // --- Registered datapath: captured request, bus strobes, response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op        <= DMI_OP_NOP;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_resp_data <= '0;
      r_resp_op   <= DMI_RESP_SUCCESS;
    end else if (w_accept) begin
      r_op        <= bus.dmi_req_op;
      r_addr      <= bus.dmi_req_addr;
      r_wdata     <= bus.dmi_req_data;
      r_rd_en     <= (bus.dmi_req_op == DMI_OP_READ);
      r_wr_en     <= (bus.dmi_req_op == DMI_OP_WRITE);
      r_resp_data <= '0;
      // NOP succeeds immediately; reserved op fails without a bus access.
      r_resp_op   <= (bus.dmi_req_op == 2'd3) ? DMI_RESP_FAILED : DMI_RESP_SUCCESS;
    end else if (w_done) begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      if (bus.reg_ack) begin
        r_resp_op   <= bus.reg_err ? DMI_RESP_FAILED : DMI_RESP_SUCCESS;
        r_resp_data <= (!bus.reg_err && (r_op == DMI_OP_READ)) ? bus.reg_rdata : 32'd0;
      end else begin
        r_resp_op   <= DMI_RESP_FAILED;
        r_resp_data <= '0;
      end
    end else if (w_resp_hs) begin
      r_resp_op   <= DMI_RESP_SUCCESS;
      r_resp_data <= '0;
    end
  end

  assign bus.dmi_req_ready  = w_req_ready;
  assign bus.dmi_resp_valid = w_resp_valid;
  assign bus.dmi_resp_data  = r_resp_data;
  assign bus.dmi_resp_op    = r_resp_op;
  assign bus.reg_rd_en      = r_rd_en;
  assign bus.reg_wr_en      = r_wr_en;
  assign bus.reg_addr       = r_addr;
  assign bus.reg_wdata      = r_wdata;

endmodule

// File: tb/tb_dmi_responder.sv
// tb_dmi_responder: directed checks of dmi_responder with hand-computed
// expectations. Inputs are driven and outputs sampled on the falling edge.
module tb_dmi_responder;
  localparam int ABITS   = 7;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmi_responder_if #(.ABITS(ABITS)) bus ();

  dmi_responder #(.ABITS(ABITS), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction. ack_at is the Access cycle (1 = first) on which
  // reg_ack is driven, 0 = never. exp_lat is the cycle after the request
  // edge at which dmi_resp_valid is first seen; hold is the number of
  // cycles dmi_resp_ready stays low once the response is up.
  task automatic run_txn(input string tag, input logic [1:0] op, input logic [6:0] addr,
                         input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata,
                         input logic err, input int hold, input int exp_rd, input int exp_wr,
                         input int exp_lat, input logic [1:0] exp_op, input logic [31:0] exp_data);
    int cyc;
    int rd_cnt;
    int wr_cnt;
    logic [31:0] d0;
    logic [1:0]  o0;
    rd_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    chk({tag, " req_ready idle"}, 32'(bus.dmi_req_ready), 32'd1);
    bus.dmi_req_valid = 1'b1;
    bus.dmi_req_op    = op;
    bus.dmi_req_addr  = addr;
    bus.dmi_req_data  = wdata;
    @(negedge clk);
    bus.dmi_req_valid = 1'b0;
    bus.dmi_req_data  = 32'h0;
    bus.dmi_req_addr  = '0;
    cyc = 1;
    while (!bus.dmi_resp_valid && cyc <= 40) begin
      if (bus.dmi_req_ready) chk({tag, " req_ready busy"}, 32'(bus.dmi_req_ready), 32'd0);
      if (bus.reg_rd_en || bus.reg_wr_en) begin
        chk({tag, " reg_addr"}, 32'(bus.reg_addr), 32'(addr));
        chk({tag, " reg_wdata"}, bus.reg_wdata, wdata);
      end
      if (bus.reg_rd_en) rd_cnt++;
      if (bus.reg_wr_en) wr_cnt++;
      bus.reg_ack   = (cyc == ack_at);
      bus.reg_rdata = (cyc == ack_at) ? rdata : 32'hBAD0BAD0;
      bus.reg_err   = (cyc == ack_at) ? err : 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.reg_ack = 1'b0;
    bus.reg_err = 1'b0;
    chk({tag, " resp latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " rd_en cycles"}, 32'(rd_cnt), 32'(exp_rd));
    chk({tag, " wr_en cycles"}, 32'(wr_cnt), 32'(exp_wr));
    chk({tag, " resp_op"}, 32'(bus.dmi_resp_op), 32'(exp_op));
    chk({tag, " resp_data"}, bus.dmi_resp_data, exp_data);
    d0 = bus.dmi_resp_data;
    o0 = bus.dmi_resp_op;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " resp_valid hold"}, 32'(bus.dmi_resp_valid), 32'd1);
      chk({tag, " resp stable"}, {bus.dmi_resp_data ^ d0} | 32'(bus.dmi_resp_op ^ o0), 32'd0);
      chk({tag, " req_ready hold"}, 32'(bus.dmi_req_ready), 32'd0);
    end
    bus.dmi_resp_ready = 1'b1;
    @(negedge clk);
    bus.dmi_resp_ready = 1'b0;
    chk({tag, " resp_valid done"}, 32'(bus.dmi_resp_valid), 32'd0);
    chk({tag, " req_ready done"}, 32'(bus.dmi_req_ready), 32'd1);
  endtask

  initial begin
    reset              = 1'b1;
    bus.dmi_req_valid  = 1'b0;
    bus.dmi_req_addr   = '0;
    bus.dmi_req_data   = '0;
    bus.dmi_req_op     = 2'd0;
    bus.dmi_resp_ready = 1'b0;
    bus.reg_rdata      = '0;
    bus.reg_ack        = 1'b0;
    bus.reg_err        = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(bus.dmi_req_ready), 32'd0);
    chk("rst resp_valid", 32'(bus.dmi_resp_valid), 32'd0);
    chk("rst resp_data", bus.dmi_resp_data, 32'd0);
    chk("rst resp_op", 32'(bus.dmi_resp_op), 32'd0);
    chk("rst strobes", {30'd0, bus.reg_rd_en, bus.reg_wr_en}, 32'd0);
    chk("rst reg_addr", 32'(bus.reg_addr), 32'd0);
    chk("rst reg_wdata", bus.reg_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready", 32'(bus.dmi_req_ready), 32'd1);

    //       tag         op  addr   wdata         ack rdata         err hold rd wr lat op data
    run_txn("wr ack1",   2'd2, 7'h10, 32'hDEADBEEF, 1, 32'h0,        0, 0, 0, 1, 2, 2'd0, 32'h0);
    run_txn("rd ack3",   2'd1, 7'h04, 32'h0,        3, 32'h12345678, 0, 5, 3, 0, 4, 2'd0, 32'h12345678);
    run_txn("rd tmo",    2'd1, 7'h08, 32'h0,        0, 32'h0,        0, 0, 16, 0, 17, 2'd2, 32'h0);
    run_txn("rd ack16",  2'd1, 7'h08, 32'h0,       16, 32'hCAFEF00D, 0, 0, 16, 0, 17, 2'd0, 32'hCAFEF00D);
    run_txn("nop",       2'd0, 7'h11, 32'h5,        0, 32'h0,        0, 0, 0, 0, 1, 2'd0, 32'h0);
    run_txn("rsvd op",   2'd3, 7'h12, 32'h6,        0, 32'h0,        0, 1, 0, 0, 1, 2'd2, 32'h0);
    run_txn("wr err",    2'd2, 7'h13, 32'h0000A5A5, 2, 32'h77777777, 1, 0, 0, 2, 3, 2'd2, 32'h0);
    run_txn("rd err",    2'd1, 7'h14, 32'h0,        1, 32'h88888888, 1, 0, 1, 0, 2, 2'd2, 32'h0);

    // Reset in the middle of an access.
    @(negedge clk);
    bus.dmi_req_valid = 1'b1;
    bus.dmi_req_op    = 2'd1;
    bus.dmi_req_addr  = 7'h20;
    @(negedge clk);
    bus.dmi_req_valid = 1'b0;
    chk("midacc rd_en", 32'(bus.reg_rd_en), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midacc rd_en rst", 32'(bus.reg_rd_en), 32'd0);
    chk("midacc addr rst", 32'(bus.reg_addr), 32'd0);
    chk("midacc resp_valid rst", 32'(bus.dmi_resp_valid), 32'd0);
    chk("midacc req_ready rst", 32'(bus.dmi_req_ready), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midacc no stale resp", 32'(bus.dmi_resp_valid), 32'd0);
    end
    run_txn("rd after rst1", 2'd1, 7'h21, 32'h0, 2, 32'h0BADCAFE, 0, 0, 2, 0, 3, 2'd0, 32'h0BADCAFE);

    // Reset while a response is pending.
    @(negedge clk);
    bus.dmi_req_valid = 1'b1;
    bus.dmi_req_op    = 2'd0;
    @(negedge clk);
    bus.dmi_req_valid = 1'b0;
    chk("midresp resp_valid", 32'(bus.dmi_resp_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midresp resp_valid rst", 32'(bus.dmi_resp_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midresp no stale resp", 32'(bus.dmi_resp_valid), 32'd0);
    end
    run_txn("rd after rst2", 2'd1, 7'h22, 32'h0, 1, 32'h13572468, 0, 2, 1, 0, 2, 2'd0, 32'h13572468);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
